rv32i_wb_queue: RTL and testbench
=================================

Name: rv32i_wb_queue

Overview:
- Write-back queue that owns the write port of the RV32I register file.
- Accepts register-write requests from the execute/load side through a valid/ready handshake.
- Buffers them in an in-order FIFO and issues at most one write per cycle on rf_wr_* unless the file side stalls.
- Offers two lookup ports so the read side can obtain the youngest pending value for a register not yet committed.

Parameters:
- NUM_OF_SETS, 32, number of architectural registers; address width is $clog2(NUM_OF_SETS).
- DATA_BUS_WIDTH, 32, register data width.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  write request present.
- in_ready  output  1  queue can accept; equals !full.
- in_addr  input  $clog2(NUM_OF_SETS)  destination register.
- in_data  input  DATA_BUS_WIDTH  value to write.
- rf_stall  input  1  register file cannot take a write this cycle.
- rf_wr_enable  output  1  write strobe to the register file.
- rf_wr_addr  output  $clog2(NUM_OF_SETS)  head entry address.
- rf_wr_data  output  DATA_BUS_WIDTH  head entry data.
- lk_addr_1, lk_addr_2  input  $clog2(NUM_OF_SETS)  lookup addresses.
- lk_hit_1, lk_hit_2  output  1  a pending entry matches.
- lk_data_1, lk_data_2  output  DATA_BUS_WIDTH  youngest matching pending data.
- count  output  $clog2(DEPTH)+1  occupied entries.
- empty, full  output  1  count==0 / count==DEPTH.

Behaviour:
- Storage: DEPTH entries of {valid, addr, data}; head and tail pointers wrap modulo DEPTH; separate count register.
- Reset: asynchronous. Clears all entry valids, addr/data, pointers and count to 0.
  - Outputs during and after reset: rf_wr_enable=0, rf_wr_addr=0, rf_wr_data=0, lk_hit_*=0, lk_data_*=0, count=0, empty=1, full=0, in_ready=1.
  - Reset asserted mid-operation discards all pending writes; none reach the file.
- Push:
  - Occurs when in_valid && in_ready at a rising edge. The entry is written at tail, and tail advances.
  - Requests with in_addr==0 are accepted (handshake completes) but not enqueued; count is unchanged.
- Issue:
  - rf_wr_enable = !empty && !rf_stall, combinational.
  - rf_wr_addr and rf_wr_data are driven from the head entry; they read 0 when empty.
  - Pop occurs at the edge where rf_wr_enable=1: the head valid clears and head advances. The file commits on the same edge.
  - Latency: a write pushed into an empty queue appears on rf_wr_* the next cycle and commits at the following edge. There is no same-cycle pass-through.
- Simultaneous push and pop: allowed whenever !full; count is unchanged.
  - When full, in_ready=0 even if a pop occurs that cycle. There is no full-bypass.
- Ordering: strictly in order; multiple pending writes to one address all commit in order.
- Lookup, combinational, stored entries only:
  - lk_hit_n=1 if any valid entry has addr==lk_addr_n and lk_addr_n!=0.
  - lk_data_n is the data of the youngest such entry, i.e. closest to tail; 0 when no hit.
  - An entry remains visible through the cycle in which it is popped.
  - The same-cycle in_* request is not visible.
- Wrap-around: pointers wrap from DEPTH-1 to 0. Lookup age ordering must remain correct across the wrap.

Optional Feature:
- Macro WBQ_LOOKUP_EN.
- Defined: the lookup ports function as specified above.
- Undefined: lk_hit_1/2 and lk_data_1/2 are tied to 0, and no comparator logic is synthesised.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset then push {addr 5, data 0xDEADBEEF} with rf_stall=0.
   - Next cycle: rf_wr_enable=1, rf_wr_addr=5, rf_wr_data=0xDEADBEEF, count=1.
   - Following cycle: empty=1, count=0.
2. Hold rf_stall=1 and push 4 writes to addr 1..4.
   - full=1, in_ready=0; a 5th request is held without loss.
   - Release the stall: commits occur in order 1,2,3,4; the 5th request is accepted on the first pop cycle+1.
3. rf_stall=1, push addr 7 data 0x11 then addr 7 data 0x22.
   - lk_addr_1=7 gives lk_hit_1=1, lk_data_1=0x22.
   - lk_addr_2=0 gives lk_hit_2=0.
   - After both pops: lk_hit_1=0.
4. Push addr 0 data 0xFFFFFFFF: handshake completes; count stays 0, rf_wr_enable stays 0, and a lookup on 0 misses.
5. Continuous stream of 10 writes with rf_stall toggling every cycle.
   - Pointers wrap; every write commits exactly once in order.
   - Lookup youngest-match holds across the wrap, e.g. addr 9 present at slots 3 and 0, with data from slot 0 returned.
6. Three entries pending, then assert rst for 1 cycle mid-stream.
   - All outputs return to reset values immediately; no further rf_wr_enable until new pushes arrive.
   - With WBQ_LOOKUP_EN undefined, scenario 3 yields lk_hit_1=0 and lk_data_1=0.

Source files
------------

// File: rtl/rv32i_wb_queue.sv
// rv32i_wb_queue: in-order register-file write-back FIFO with youngest-match lookup ports.
// Define WBQ_LOOKUP_EN to build the lookup comparators; otherwise lk_* outputs are tied to 0.
module rv32i_wb_queue #(
  parameter int NUM_OF_SETS    = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int DEPTH          = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [$clog2(NUM_OF_SETS)-1:0] in_addr,
  input  logic [DATA_BUS_WIDTH-1:0]      in_data,
  input  logic                           rf_stall,
  output logic                           rf_wr_enable,
  output logic [$clog2(NUM_OF_SETS)-1:0] rf_wr_addr,
  output logic [DATA_BUS_WIDTH-1:0]      rf_wr_data,
  input  logic [$clog2(NUM_OF_SETS)-1:0] lk_addr_1,
  input  logic [$clog2(NUM_OF_SETS)-1:0] lk_addr_2,
  output logic                           lk_hit_1,
  output logic                           lk_hit_2,
  output logic [DATA_BUS_WIDTH-1:0]      lk_data_1,
  output logic [DATA_BUS_WIDTH-1:0]      lk_data_2,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           empty,
  output logic                           full
);
  localparam int AW = $clog2(NUM_OF_SETS);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]          vld;
  logic [AW-1:0]             addr_q [DEPTH];
  logic [DATA_BUS_WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]             head, tail;
  logic                      push, pop;

  assign empty        = count == '0;
  assign full         = count == CW'(DEPTH);
  assign in_ready     = !full;
  // Writes to x0 complete the handshake but are dropped here.
  assign push         = in_valid && in_ready && in_addr != '0;
  assign pop          = rf_wr_enable;
  assign rf_wr_enable = !empty && !rf_stall;
  assign rf_wr_addr   = empty ? '0 : addr_q[head];
  assign rf_wr_data   = empty ? '0 : data_q[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        vld[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      if (push) begin
        vld[tail]    <= 1'b1;
        addr_q[tail] <= in_addr;
        data_q[tail] <= in_data;
        tail         <= tail + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

`ifdef WBQ_LOOKUP_EN
  // Walk oldest to youngest from head so the last match seen is the youngest, wrap included.
  always_comb begin
    lk_hit_1  = 1'b0;
    lk_hit_2  = 1'b0;
    lk_data_1 = '0;
    lk_data_2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[PW'(head + PW'(i))] && lk_addr_1 != '0 && addr_q[PW'(head + PW'(i))] == lk_addr_1) begin
        lk_hit_1  = 1'b1;
        lk_data_1 = data_q[PW'(head + PW'(i))];
      end
      if (vld[PW'(head + PW'(i))] && lk_addr_2 != '0 && addr_q[PW'(head + PW'(i))] == lk_addr_2) begin
        lk_hit_2  = 1'b1;
        lk_data_2 = data_q[PW'(head + PW'(i))];
      end
    end
  end
`else
  wire unused_lk = ^{lk_addr_1, lk_addr_2};
  assign lk_hit_1  = 1'b0;
  assign lk_hit_2  = 1'b0;
  assign lk_data_1 = '0;
  assign lk_data_2 = '0;
`endif
endmodule

// File: tb/tb_rv32i_wb_queue.sv
// tb_rv32i_wb_queue: directed and random stimulus checked against a queue-based reference model.
module tb_rv32i_wb_queue;
  localparam int DEPTH = 4;
`ifdef WBQ_LOOKUP_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [4:0]  in_addr = '0;
  logic [31:0] in_data = '0;
  logic        rf_stall = 1'b0, rf_wr_enable;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [4:0]  lk_addr_1 = '0, lk_addr_2 = '0;
  logic        lk_hit_1, lk_hit_2;
  logic [31:0] lk_data_1, lk_data_2;
  logic [2:0]  count;
  logic        empty, full;

  int checks = 0;
  int errors = 0;
  logic [4:0]  qa[$];
  logic [31:0] qd[$];

  rv32i_wb_queue #(.NUM_OF_SETS(32), .DATA_BUS_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .rf_stall(rf_stall),
    .rf_wr_enable(rf_wr_enable), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .lk_addr_1(lk_addr_1), .lk_addr_2(lk_addr_2), .lk_hit_1(lk_hit_1), .lk_hit_2(lk_hit_2),
    .lk_data_1(lk_data_1), .lk_data_2(lk_data_2), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_lk(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (LK && a != 0)
      foreach (qa[i]) if (qa[i] == a) begin h = 1'b1; d = qd[i]; end
  endtask

  task automatic chk_reset();
    check("rst_wr_en", rf_wr_enable, 0);
    check("rst_wr_addr", rf_wr_addr, 0);
    check("rst_wr_data", rf_wr_data, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_lk_hit", {lk_hit_1, lk_hit_2}, 0);
    check("rst_lk_data", lk_data_1 | lk_data_2, 0);
  endtask

  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic s, input logic [4:0] l1, input logic [4:0] l2);
    logic h;
    logic [31:0] ld;
    bit pop, push;
    in_valid = v; in_addr = a; in_data = d; rf_stall = s; lk_addr_1 = l1; lk_addr_2 = l2;
    #1;
    pop  = qa.size() > 0 && !s;
    push = v && qa.size() < DEPTH && a != 0;
    check("count", 32'(count), qa.size());
    check("empty", empty, qa.size() == 0);
    check("full", full, qa.size() == DEPTH);
    check("in_ready", in_ready, qa.size() < DEPTH);
    check("wr_en", rf_wr_enable, pop);
    check("wr_addr", rf_wr_addr, qa.size() > 0 ? qa[0] : 5'd0);
    check("wr_data", rf_wr_data, qa.size() > 0 ? qd[0] : 32'd0);
    model_lk(l1, h, ld);
    check("lk_hit_1", lk_hit_1, h);
    check("lk_data_1", lk_data_1, ld);
    model_lk(l2, h, ld);
    check("lk_hit_2", lk_hit_2, h);
    check("lk_data_2", lk_data_2, ld);
    @(posedge clk);
    if (pop) begin void'(qa.pop_front()); void'(qd.pop_front()); end
    if (push) begin qa.push_back(a); qd.push_back(d); end
    @(negedge clk);
  endtask

  initial begin
    #1 chk_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Single write latency
    step(1, 5, 32'hDEADBEEF, 0, 5, 0);
    step(0, 0, 0, 0, 5, 0);
    step(0, 0, 0, 0, 5, 0);
    // Fill under stall, hold a fifth request, then drain in order
    for (int i = 1; i <= 4; i++) step(1, 5'(i), 32'h100 * i, 1, 5'(i), 3);
    step(1, 5, 32'h500, 1, 2, 4);
    step(1, 5, 32'h500, 0, 1, 5);
    step(1, 5, 32'h500, 0, 5, 2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 5, 4);
    // Two writes to one register: youngest wins, x0 never hits
    step(1, 7, 32'h11, 1, 7, 0);
    step(1, 7, 32'h22, 1, 7, 0);
    step(0, 0, 0, 1, 7, 0);
    check("s3_lk_data_1", lk_data_1, LK ? 32'h22 : 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 7, 0);
    // x0 write is swallowed
    step(1, 0, 32'hFFFFFFFF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // Stream with toggling stall to force wrap, addr 9 repeated
    for (int i = 0; i < 10; i++)
      step(1, (i % 3 == 0) ? 5'd9 : 5'($urandom_range(1, 31)), $urandom, 1'(i % 2), 9, 5'($urandom_range(0, 31)));
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1'(i % 2), 9, 0);
    // Asynchronous reset mid-stream discards pending writes
    for (int i = 0; i < 3; i++) step(1, 5'(i + 3), $urandom, 1, 4, 5);
    #2 rst = 1'b1;
    #1 chk_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    qa.delete();
    qd.delete();
    step(0, 0, 0, 0, 4, 5);
    step(0, 0, 0, 0, 3, 5);
    // Random traffic with a small address range for frequent collisions
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
